// File: rtl/spongent_squeeze_pkg.sv
// spongent_squeeze_pkg: Spongent-88/176/88 constants, FSM encoding and permutation helpers
package spongent_squeeze_pkg;
  localparam int N_SBOX = 33;
  localparam int RATE_BITS = 88;
  localparam int R_SIZE_BYTES = RATE_BITS / 8;
  localparam int N_ROUNDS = 135;
  localparam int LFSR_W = 7;
  localparam logic [LFSR_W-1:0] LFSR_INIT = 7'h45;
  localparam logic [63:0] SBOX_TABLE = 64'h63C958A7F4120BDE;
  typedef enum logic [1:0] {IDLE, EMIT, PERM} fsm_t;
  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction
  // x^7 + x^6 + 1 round-constant counter
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], x[6] ^ x[5]};
  endfunction
  function automatic logic [LFSR_W-1:0] bit_rev(input logic [LFSR_W-1:0] x);
    logic [LFSR_W-1:0] r;
    for (int i = 0; i < LFSR_W; i++) r[i] = x[LFSR_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/spongent_squeeze_round.sv
// spongent_squeeze_round: one combinational Spongent round (counter XOR, sBoxLayer, pLayer)
module spongent_squeeze_round
  import spongent_squeeze_pkg::*;
#(
  parameter int STATE_W = N_SBOX * 8
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic [LFSR_W-1:0]  lfsr_i,
  output logic [STATE_W-1:0] state_o
);
  logic [STATE_W-1:0] x, s;
  always_comb begin
    x = state_i;
    x[LFSR_W-1:0] = state_i[LFSR_W-1:0] ^ lfsr_i;
    x[STATE_W-1 -: LFSR_W] = state_i[STATE_W-1 -: LFSR_W] ^ bit_rev(lfsr_i);
  end
  for (genvar i = 0; i < STATE_W / 4; i++) begin : g_s
    assign s[4*i +: 4] = sbox(x[4*i +: 4]);
  end
  // bit j moves to j*b/4 mod (b-1); the top bit stays put
  for (genvar j = 0; j < STATE_W; j++) begin : g_p
    assign state_o[j == STATE_W - 1 ? j : (j * (STATE_W / 4)) % (STATE_W - 1)] = s[j];
  end
endmodule

// File: rtl/spongent_squeeze.sv
// spongent_squeeze: streams the sponge state out bytewise, permuting between rate blocks
module spongent_squeeze
  import spongent_squeeze_pkg::*;
#(
  parameter int STATE_W = N_SBOX * 8,
  parameter int RATE    = RATE_BITS,
  parameter int HASH_W  = RATE_BITS,
  parameter int ROUNDS  = N_ROUNDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state_in,
  input  logic               start,
  output logic               busy,
  output logic [7:0]         hash_byte,
  output logic               hash_valid,
  input  logic               hash_ready,
  output logic               done
);
  localparam int RB = RATE / 8;
  localparam int HB = HASH_W / 8;
  localparam int BI_W = $clog2(RB + 1);
  localparam int BO_W = $clog2(HB + 1);
  localparam int RC_W = $clog2(ROUNDS + 1);
  localparam logic [BI_W-1:0] LAST_RATE = BI_W'(RB - 1);
  localparam logic [BO_W-1:0] LAST_HASH = BO_W'(HB - 1);
  localparam logic [RC_W-1:0] LAST_ROUND = RC_W'(ROUNDS - 1);
  fsm_t fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d, round_out;
  logic [BI_W-1:0] byte_idx_q, byte_idx_d;
  logic [BO_W-1:0] bytes_out_q, bytes_out_d;
  logic [RC_W-1:0] round_ctr_q, round_ctr_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic done_q, done_d, accept, xfer, last_hash, last_rate, last_round;
  spongent_squeeze_round #(.STATE_W(STATE_W)) u_round (
    .state_i(state_q),
    .lfsr_i (lfsr_q),
    .state_o(round_out)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      byte_idx_q  <= '0;
      bytes_out_q <= '0;
      round_ctr_q <= '0;
      lfsr_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      bytes_out_q <= bytes_out_d;
      round_ctr_q <= round_ctr_d;
      lfsr_q      <= lfsr_d;
      done_q      <= done_d;
    end
  end
  // the final hash byte takes priority over the end-of-block permutation
  always_comb begin
    accept = fsm_q == IDLE && start;
    xfer = fsm_q == EMIT && hash_ready;
    last_hash = bytes_out_q == LAST_HASH;
    last_rate = byte_idx_q == LAST_RATE;
    last_round = round_ctr_q == LAST_ROUND;
    fsm_d = fsm_q == IDLE ? (start ? EMIT : IDLE)
          : fsm_q == EMIT ? (xfer && last_hash ? IDLE : xfer && last_rate ? PERM : EMIT)
          : (last_round ? EMIT : PERM);
    state_d = accept ? state_in : fsm_q == PERM ? round_out : state_q;
    byte_idx_d = accept || (xfer && last_rate) ? '0 : xfer ? byte_idx_q + 1'b1 : byte_idx_q;
    bytes_out_d = accept ? '0 : xfer ? bytes_out_q + 1'b1 : bytes_out_q;
    round_ctr_d = fsm_q == PERM && !last_round ? round_ctr_q + 1'b1 : '0;
    lfsr_d = accept || (fsm_q == PERM && last_round) ? LFSR_INIT
           : fsm_q == PERM ? lfsr_next(lfsr_q) : lfsr_q;
    done_d = xfer && last_hash;
  end
  always_comb begin
    hash_valid = fsm_q == EMIT;
    busy = fsm_q != IDLE;
    hash_byte = hash_valid ? state_q[{byte_idx_q, 3'b000} +: 8] : 8'h00;
    done = done_q;
  end
endmodule

// File: tb/tb_spongent_squeeze.sv
// tb_spongent_squeeze: scoreboard bench for an 88-bit and a 176-bit hash instance
module tb_spongent_squeeze;
  localparam int SW = 264;
  localparam int GAP = 136;
  logic clk = 0, rst = 0;
  logic start0 = 0, start1 = 0, ready0 = 1, ready1 = 1;
  logic [SW-1:0] st0 = '0, st1 = '0;
  logic busy0, busy1, hv0, hv1, done0, done1;
  logic [7:0] hb0, hb1;
  int n_cmp = 0, n_bad = 0, cyc = 0, ph = 0;
  int mode0 = 0, mode1 = 0, x0 = 0, x1 = 0, dn0 = 0, dn1 = 0, e0 = 0, e1 = 0, lx1 = 0;
  logic [7:0] q0[$], q1[$];
  logic pv0 = 0, pr0 = 0, pv1 = 0, pr1 = 0;
  logic [7:0] pb0 = 0, pb1 = 0;
  logic [3:0] sb [16] = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
                          4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spongent_squeeze d0 (.clk(clk), .rst(rst), .state_in(st0), .start(start0), .busy(busy0),
    .hash_byte(hb0), .hash_valid(hv0), .hash_ready(ready0), .done(done0));
  spongent_squeeze #(.HASH_W(176)) d1 (.clk(clk), .rst(rst), .state_in(st1), .start(start1),
    .busy(busy1), .hash_byte(hb1), .hash_valid(hv1), .hash_ready(ready1), .done(done1));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", n, a, e);
    end
  endtask

  task automatic expire(input string n);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", n);
  endtask

  // Reference Spongent permutation: 135 rounds of counter XOR, S-box, bit permutation
  function automatic logic [SW-1:0] perm(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    logic [3:0] nib;
    int c = 'h45;
    for (int r = 0; r < 135; r++) begin
      for (int i = 0; i < 7; i++) begin
        s[i] = s[i] ^ c[i];
        s[SW-1-i] = s[SW-1-i] ^ c[i];
      end
      for (int n = 0; n < SW / 4; n++) begin
        nib = s[4*n +: 4];
        s[4*n +: 4] = sb[nib];
      end
      for (int j = 0; j < SW; j++) t[j == SW - 1 ? j : (j * (SW / 4)) % (SW - 1)] = s[j];
      s = t;
      c = ((c << 1) | (((c >> 6) ^ (c >> 5)) & 1)) & 'h7f;
    end
    return s;
  endfunction

  function automatic logic [SW-1:0] rnd();
    logic [SW-1:0] r;
    for (int i = 0; i < SW / 8; i++) r[8*i +: 8] = 8'($urandom);
    return r;
  endfunction

  task automatic push0(input logic [SW-1:0] s);
    for (int i = 0; i < 11; i++) q0.push_back(s[8*i +: 8]);
    e0++;
  endtask

  task automatic push1(input logic [SW-1:0] s);
    logic [SW-1:0] p = perm(s);
    for (int i = 0; i < 11; i++) q1.push_back(s[8*i +: 8]);
    for (int i = 0; i < 11; i++) q1.push_back(p[8*i +: 8]);
    e1++;
  endtask

  task automatic issue0(input logic [SW-1:0] s);
    @(negedge clk);
    st0 = s;
    start0 = 1;
    push0(s);
    @(negedge clk);
    start0 = 0;
    chk("valid_after_start0", hv0, 1);
    chk("busy_after_start0", busy0, 1);
  endtask

  task automatic issue1(input logic [SW-1:0] s);
    @(negedge clk);
    st1 = s;
    start1 = 1;
    push1(s);
    @(negedge clk);
    start1 = 0;
    chk("valid_after_start1", hv1, 1);
  endtask

  task automatic wait_all(input int budget);
    int n = 0;
    while ((dn0 < e0 || dn1 < e1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (dn0 < e0 || dn1 < e1) expire("done_wait");
  endtask

  always @(posedge clk) begin
    #1;
    ph++;
    ready0 = mode0 == 0 ? 1'b1 : mode0 == 1 ? (ph % 3 == 0) : 1'($urandom_range(0, 1));
    ready1 = mode1 == 0 ? 1'b1 : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst) begin
      if (pv0 && !pr0) begin
        chk("stall_hold0", hv0, 1);
        chk("stall_byte0", hb0, pb0);
      end
      if (hv0 && ready0) begin
        x0++;
        if (q0.size() == 0) expire("extra_byte0");
        else chk("byte0", hb0, q0.pop_front());
      end
      if (done0) begin
        dn0++;
        chk("done0_all_sent", q0.size(), 0);
        chk("done0_idle", {busy0, hv0}, 0);
      end
      pv0 = hv0;
      pr0 = ready0;
      pb0 = hb0;
    end else pv0 = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (pv1 && !pr1) begin
        chk("stall_hold1", hv1, 1);
        chk("stall_byte1", hb1, pb1);
      end
      if (!pv1 && hv1 && q1.size() == 11) chk("perm_gap1", cyc - lx1, GAP);
      if (hv1 && ready1) begin
        x1++;
        lx1 = cyc;
        if (q1.size() == 0) expire("extra_byte1");
        else chk("byte1", hb1, q1.pop_front());
      end
      if (done1) begin
        dn1++;
        chk("done1_all_sent", q1.size(), 0);
        chk("done1_idle", {busy1, hv1}, 0);
      end
      pv1 = hv1;
      pr1 = ready1;
      pb1 = hb1;
    end else pv1 = 0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles", cyc);
    $fatal(1);
  end

  initial begin
    logic [SW-1:0] s, inc;
    int n;
    for (int i = 0; i < SW / 8; i++) inc[8*i +: 8] = 8'(i);
    repeat (3) @(negedge clk);
    chk("rst_busy0", busy0, 0);
    chk("rst_valid0", hv0, 0);
    chk("rst_byte0", hb0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_valid1", hv1, 0);
    rst = 1;
    @(negedge clk);
    // incrementing bytes, ready held high: 11 consecutive bytes, done at k+12
    issue0(inc);
    repeat (11) @(negedge clk);
    chk("done_at_k12", done0, 1);
    wait_all(50);
    // same stream with ready pattern 1,0,0,...
    mode0 = 1;
    issue0(inc);
    wait_all(200);
    // 176-bit hash of the zero state crosses one permutation
    issue1('0);
    wait_all(400);
    // start held while busy must not restart
    mode0 = 0;
    s = rnd();
    @(negedge clk);
    st0 = s;
    start0 = 1;
    push0(s);
    repeat (8) begin
      @(negedge clk);
      st0 = rnd();
    end
    start0 = 0;
    wait_all(100);
    issue0(rnd());
    wait_all(100);
    // reset after the 5th transfer
    n = x0 + 5;
    issue0(rnd());
    for (int k = 0; k < 50 && x0 < n; k++) @(negedge clk);
    if (x0 < n) expire("reach_byte5");
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("abort_valid0", hv0, 0);
    chk("abort_busy0", busy0, 0);
    chk("abort_byte0", hb0, 0);
    q0.delete();
    e0--;
    repeat (3) @(negedge clk);
    chk("abort_done0", done0, 0);
    rst = 1;
    issue0(inc);
    wait_all(100);
    // reset in the middle of the permutation
    n = x1 + 11;
    issue1(rnd());
    for (int k = 0; k < 50 && x1 < n; k++) @(negedge clk);
    if (x1 < n) expire("reach_perm");
    repeat (60) @(negedge clk);
    chk("in_perm_busy1", busy1, 1);
    #2 rst = 0;
    #1;
    chk("abort_valid1", hv1, 0);
    chk("abort_busy1", busy1, 0);
    q1.delete();
    e1--;
    repeat (2) @(negedge clk);
    rst = 1;
    issue1(rnd());
    wait_all(400);
    // random states with random back-pressure on both instances
    mode0 = 2;
    mode1 = 2;
    for (int t = 0; t < 6; t++) begin
      issue0(rnd());
      issue1(rnd());
      wait_all(2000);
    end
    chk("queue0_empty", q0.size(), 0);
    chk("queue1_empty", q1.size(), 0);
    chk("done_count0", dn0, e0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spongent_squeeze.md
# spongent_squeeze

Squeezing phase of the Spongent sponge, the read-side counterpart of `Absorb`. Latches the final absorbed state, streams the hash out one byte at a time over a valid/ready handshake, and runs the Spongent permutation between rate blocks whenever the hash is longer than the rate. Sits between the absorb datapath and the host-side hash output port.

## Interface
- `STATE_W`, 264, permutation width b; equals `nSBox`*8.
- `RATE`, 88, rate r in bits; multiple of 8, equals `R_SizeInBytes`*8.
- `HASH_W`, 88, hash length n in bits; multiple of 8, at least 8.
- `ROUNDS`, 135, permutation rounds per call.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. Keeps the codebase name `rst`; polarity is low-active.
- `state_in` in STATE_W: absorbed state; sampled only on an accepted `start`.
- `start` in 1: request to squeeze `state_in`.
- `busy` out 1: high from the cycle after an accepted `start` until the cycle after `done`.
- `hash_byte` out 8: current output byte.
- `hash_valid` out 1: `hash_byte` is valid.
- `hash_ready` in 1: consumer accepts `hash_byte`.
- `done` out 1: one-cycle pulse after the last hash byte transfers.

## Operation
- States: IDLE, EMIT, PERM.
- Counters:
  - `byte_idx` counts 0..RATE/8-1 within the current block.
  - `bytes_out` counts 0..HASH_W/8 over the whole hash.
  - `round_ctr` counts 0..ROUNDS-1.
  - The round-constant LFSR is loaded from `LFSR_INIT`.
- IDLE: `start`=1 latches `state_in` into the internal state register, clears all counters, and moves to EMIT.
- EMIT:
  - `hash_valid`=1.
  - `hash_byte` = state[8*`byte_idx` +: 8]. This is the same byte order `Absorb` uses for XORing, so byte 0 is state[7:0].
  - A transfer (`hash_valid` & `hash_ready`) increments `byte_idx` and `bytes_out`.
  - Transfer of the last hash byte (`bytes_out` = HASH_W/8-1): pulse `done`, return to IDLE.
  - Otherwise, transfer of the last rate byte (`byte_idx` = RATE/8-1): clear `byte_idx`, move to PERM.
- PERM:
  - One round per cycle, applied as state <= `spongent_round`(state, lfsr).
  - After ROUNDS rounds: reload the LFSR, clear `round_ctr`, move to EMIT.
  - `hash_valid`=0 throughout.
- With the defaults (HASH_W = RATE) there is no PERM: exactly 11 bytes are emitted.
- `start` is ignored outside IDLE.
- When `done` pulses, `start` is honoured on the following cycle (IDLE).

## Timing
- Reset values: `busy`=0, `hash_valid`=0, `done`=0, `hash_byte`=0; state register, counters and LFSR cleared; FSM in IDLE.
- Reset mid-squeeze aborts immediately. No `done` is produced and no further bytes are emitted.
- Accepted `start` at edge k gives `hash_valid`=1 and `busy`=1 from cycle k+1.
- With `hash_ready` held high, one byte transfers per cycle.
- Each permutation costs exactly ROUNDS cycles with `hash_valid`=0.
  - The first byte of block j+1 is valid ROUNDS+1 cycles after the last byte of block j transfers.
- `hash_byte` holds stable while `hash_valid`=1 and `hash_ready`=0. `hash_valid` never drops without a transfer.
- `done` is asserted in the cycle after the final transfer edge, together with `busy`=0 and `hash_valid`=0.
- `hash_ready` is don't-care when `hash_valid`=0.

## Structure
- `constants.vh` holds:
  - `nSBox`, `rate`, `R_SizeInBytes`, `ROUNDS`.
  - The 4-bit S-box table.
  - `LFSR_INIT`, the 7-bit initial value, plus the LFSR feedback taps.
  - These are shared with `Absorb` so both phases use an identical permutation.
- Sub-module `spongent_round` (combinational): round-constant XOR (LFSR value and its bit-reverse into state LSB/MSB), sBoxLayer, pLayer. Shared with `Absorb`.
- `spongent_squeeze` contains the FSM, counters, LFSR and state register.

## Test plan
- Defaults; `state_in` byte i = i (i = 0..32); `start` pulse; `hash_ready`=1.
  - Expect bytes 0x00,0x01,…,0x0A on consecutive cycles from k+1.
  - Expect `done` at k+12 and no PERM cycles.
- Same stimulus with `hash_ready` toggling 1,0,0,1,…
  - Expect the same 11-byte sequence.
  - `hash_byte` stable during stalls; no byte duplicated or skipped.
- HASH_W=176, state = all zeros.
  - Expect 11 zero bytes, then 135 cycles with `hash_valid`=0.
  - The next 11 bytes equal state[87:0] of a software Spongent permutation of zero; `done` follows the last of them.
- `start` asserted repeatedly while `busy`=1.
  - Expect no restart and an unchanged output sequence.
  - `start` one cycle after `done` launches a new squeeze of the new `state_in`.
- `rst` driven low after the 5th byte transfer, or in the middle of PERM.
  - Expect all outputs to drop to 0 asynchronously.
  - After release, a fresh `start` yields the full, correct sequence from byte 0.
- End-to-end: `Absorb` on "Hello WorldHello World" (176 bits, 2 blocks), its `state_out` then fed to `spongent_squeeze`.
  - The 11 bytes must match the reference Spongent-88/176/88 hash.
